// File: rtl/rom_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rom_ctrl_pkg : shared types and defaults for the switch-programmed memory
// Revision 1.0
// ---------------------------------------------------------------------------
package rom_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    CLR_ALL = 2'd2,
    SCAN    = 2'd3
  } state_e;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 5;
  localparam int DEF_DEPTH = 32;

  localparam logic [DEF_DW-1:0] ZERO_WORD = '0;

endpackage
`default_nettype wire

// File: rtl/rom_ctrl_btn_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_sync : two-flop synchroniser with a previous-value flop for rise detect
// Revision 1.0
// ---------------------------------------------------------------------------
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic meta_q;
  logic level_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      meta_q  <= i_async;
      level_q <= meta_q;
      prev_q  <= level_q;
    end
  end

  assign o_level = level_q;
  assign o_rise  = level_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/rom_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rom_ctrl : 32 x 8 switch-programmed store with write/clear/sweep/scan FSM
// Revision 1.0
// ---------------------------------------------------------------------------
module rom_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int SCAN_TICKS = 25_000_000
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [DW-1:0] D,
  input  logic [AW-1:0] A,
  input  logic          Load,
  input  logic          Clear,
  input  logic          Scan,
  output logic [DW-1:0] LED,
  output logic [AW-1:0] Ao,
  output logic          Busy
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

  logic w_load_s, w_load_rise;
  logic w_clear_s, w_clear_rise;
  logic w_scan_s, w_scan_rise_unused;

  btn_sync u_load_sync  (.clk(Clk), .rst_n(Rst_n), .i_async(Load),
                         .o_level(w_load_s),  .o_rise(w_load_rise));
  btn_sync u_clear_sync (.clk(Clk), .rst_n(Rst_n), .i_async(Clear),
                         .o_level(w_clear_s), .o_rise(w_clear_rise));
  btn_sync u_scan_sync  (.clk(Clk), .rst_n(Rst_n), .i_async(Scan),
                         .o_level(w_scan_s),  .o_rise(w_scan_rise_unused));

  state_e        state_q, state_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic [AW-1:0] scan_ptr_q, scan_ptr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [AW-1:0] ao_q, ao_d;
  logic [DW-1:0] led_q, led_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] w_disp_addr;

  always_comb begin
    state_d    = state_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    sweep_d    = sweep_q;
    scan_ptr_d = scan_ptr_q;
    tick_d     = tick_q;
    mem_d      = mem_q;
    unique case (state_q)
      IDLE: begin
        // Chord of both buttons wins over either single press.
        if (w_load_s && w_clear_s && (w_load_rise || w_clear_rise)) begin
          state_d = CLR_ALL;
          sweep_d = '0;
        end else if (w_load_rise) begin
          state_d = WRITE;
          wa_d    = A;
          wd_d    = D;
        end else if (w_clear_rise) begin
          state_d = WRITE;
          wa_d    = A;
          wd_d    = DW'(ZERO_WORD);
        end else if (w_scan_s) begin
          state_d    = SCAN;
          scan_ptr_d = '0;
          tick_d     = '0;
        end
      end
      WRITE: begin
        mem_d[wa_q] = wd_q;
        state_d     = IDLE;
      end
      CLR_ALL: begin
        mem_d[sweep_q] = DW'(ZERO_WORD);
        sweep_d        = sweep_q + AW'(1);
        if (sweep_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      SCAN: begin
        if (tick_q == TW'(SCAN_TICKS - 1)) begin
          tick_d     = '0;
          scan_ptr_d = (scan_ptr_q == AW'(DEPTH - 1)) ? '0 : scan_ptr_q + AW'(1);
        end else begin
          tick_d = tick_q + TW'(1);
        end
        if (!w_scan_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (state_q)
      CLR_ALL: w_disp_addr = sweep_q;
      SCAN:    w_disp_addr = scan_ptr_q;
      default: w_disp_addr = A;
    endcase
  end

  // Reads come from the pre-edge array, so a same-cycle write shows next edge.
  assign ao_d  = w_disp_addr;
  assign led_d = mem_q[w_disp_addr];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      wa_q       <= '0;
      wd_q       <= '0;
      sweep_q    <= '0;
      scan_ptr_q <= '0;
      tick_q     <= '0;
      ao_q       <= '0;
      led_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      sweep_q    <= sweep_d;
      scan_ptr_q <= scan_ptr_d;
      tick_q     <= tick_d;
      ao_q       <= ao_d;
      led_q      <= led_d;
      mem_q      <= mem_d;
    end
  end

  assign LED  = led_q;
  assign Ao   = ao_q;
  assign Busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rom_ctrl : directed + randomized bench for rom_ctrl against a word-array model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_rom_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [7:0] D = '0;
  logic [4:0] A = '0;
  logic       Load = 1'b0;
  logic       Clear = 1'b0;
  logic       Scan = 1'b0;
  logic [7:0] LED;
  logic [4:0] Ao;
  logic       Busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_mem [32];

  rom_ctrl #(.DW(8), .AW(5), .DEPTH(32), .SCAN_TICKS(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .D(D), .A(A), .Load(Load), .Clear(Clear),
    .Scan(Scan), .LED(LED), .Ao(Ao), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input logic [4:0] addr);
    A = addr;
    tick(1);
    check("read_ao", 32'(Ao), 32'(addr));
    check("read_led", 32'(LED), 32'(model_mem[addr]));
  endtask

  // One button press held for three cycles; switches are scrambled once the
  // write has been captured, then restored for the readback.
  task automatic do_op(input logic [4:0] addr, input logic [7:0] data, input bit use_clear);
    int busy_cnt;
    busy_cnt = 0;
    A = addr;
    D = data;
    if (use_clear) Clear = 1'b1; else Load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      busy_cnt += int'(Busy);
      if (i == 2) begin
        Load  = 1'b0;
        Clear = 1'b0;
        A     = ~addr;
        D     = ~data;
      end
      if (i == 4) A = addr;
    end
    model_mem[addr] = use_clear ? 8'h00 : data;
    check("op_busy_cycles", 32'(busy_cnt), 32'd1);
    check("op_ao", 32'(Ao), 32'(addr));
    check("op_led", 32'(LED), 32'(model_mem[addr]));
  endtask

  initial begin
    logic [4:0] a0;
    logic [7:0] d0;
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;

    // Reset state
    #12;
    check("rst_led", 32'(LED), 32'h0);
    check("rst_ao", 32'(Ao), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    Rst_n = 1'b1;
    tick(2);

    // 1: write 0xA5 at 5 with edge-accurate latency
    A = 5'd5; D = 8'hA5; Load = 1'b1;
    tick(1); check("t1_busy_e1", 32'(Busy), 32'd0);
    tick(1); check("t1_busy_e2", 32'(Busy), 32'd0);
    tick(1); check("t1_busy_e3", 32'(Busy), 32'd1);
    Load = 1'b0;
    tick(1); check("t1_busy_e4", 32'(Busy), 32'd0);
    check("t1_led_old_e4", 32'(LED), 32'h00);
    tick(1); check("t1_led_e5", 32'(LED), 32'hA5);
    check("t1_ao_e5", 32'(Ao), 32'd5);
    model_mem[5] = 8'hA5;
    read_check(5'd6);
    read_check(5'd5);

    // 2: single-word clear leaves its neighbour alone
    do_op(5'd31, 8'h3C, 1'b0);
    do_op(5'd30, 8'($urandom_range(1, 255)), 1'b0);
    A = 5'd31; Clear = 1'b1;
    tick(1); Clear = 1'b0;
    tick(3); check("t2_led_old_e4", 32'(LED), 32'h3C);
    tick(1); check("t2_led_e5", 32'(LED), 32'h00);
    model_mem[31] = 8'h00;
    read_check(5'd30);

    // Randomized single-word writes and clears
    for (int n = 0; n < 16; n++) begin
      do_op(5'($urandom_range(0, 31)), 8'($urandom), bit'($urandom_range(0, 3) == 0));
      read_check(5'($urandom_range(0, 31)));
    end

    // 3: whole-array sweep via Clear held then Load pressed
    do_op(5'd0, 8'hFF, 1'b0);
    do_op(5'd17, 8'hFF, 1'b0);
    do_op(5'd31, 8'hFF, 1'b0);
    A = 5'd17; Clear = 1'b1;
    tick(8);
    model_mem[17] = 8'h00;
    check("t3_clear_write_led", 32'(LED), 32'h00);
    Load = 1'b1;
    tick(2); check("t3_busy_pre", 32'(Busy), 32'd0);
    for (int j = 0; j < 32; j++) begin
      tick(1);
      check("t3_busy_sweep", 32'(Busy), 32'd1);
      if (j > 0) check("t3_ao_step", 32'(Ao), 32'(j - 1));
    end
    tick(1);
    check("t3_busy_done", 32'(Busy), 32'd0);
    check("t3_ao_last", 32'(Ao), 32'd31);
    Load = 1'b0; Clear = 1'b0;
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    tick(3);
    for (int i = 0; i < 32; i++) read_check(5'(i));

    // 4: auto-scan with an ignored Load in the middle
    for (int n = 0; n < 6; n++) do_op(5'($urandom_range(0, 31)), 8'($urandom), 1'b0);
    a0 = 5'($urandom_range(0, 31));
    A = a0;
    tick(1);
    Scan = 1'b1;
    tick(3); check("t4_busy_scan", 32'(Busy), 32'd1);
    for (int k = 0; k < 132; k++) begin
      tick(1);
      check("t4_scan_ao", 32'(Ao), 32'((k / 4) % 32));
      check("t4_scan_led", 32'(LED), 32'(model_mem[(k / 4) % 32]));
      if (k == 20) begin
        D = 8'($urandom);
        Load = 1'b1;
      end
      if (k == 26) Load = 1'b0;
    end
    Scan = 1'b0;
    tick(4);
    check("t4_busy_exit", 32'(Busy), 32'd0);
    check("t4_ao_exit", 32'(Ao), 32'(a0));
    for (int i = 0; i < 32; i++) read_check(5'(i));

    // 5: asynchronous reset part-way through a sweep
    do_op(5'd20, 8'($urandom_range(1, 255)), 1'b0);
    do_op(5'd3, 8'($urandom_range(1, 255)), 1'b0);
    A = 5'd20;
    tick(1);
    Load = 1'b1; Clear = 1'b1;
    tick(13);
    check("t5_busy_mid", 32'(Busy), 32'd1);
    check("t5_ao_mid", 32'(Ao), 32'd9);
    #1 Rst_n = 1'b0;
    #1;
    check("t5_rst_led", 32'(LED), 32'h0);
    check("t5_rst_ao", 32'(Ao), 32'h0);
    check("t5_rst_busy", 32'(Busy), 32'h0);
    Load = 1'b0; Clear = 1'b0;
    tick(2);
    Rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    tick(2);
    for (int i = 0; i < 32; i++) read_check(5'(i));

    // 6: Load rise landing in the WRITE cycle of a Clear is dropped
    d0 = 8'($urandom_range(1, 255));
    do_op(5'd12, d0, 1'b0);
    A = 5'd12; D = ~d0 | 8'h01; Clear = 1'b1;
    tick(1); Clear = 1'b0; Load = 1'b1;
    tick(2); check("t6_busy_write", 32'(Busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t6_busy_idle", 32'(Busy), 32'd0);
    end
    Load = 1'b0;
    model_mem[12] = 8'h00;
    check("t6_led", 32'(LED), 32'h00);
    tick(4);
    check("t6_busy_release", 32'(Busy), 32'd0);
    for (int i = 0; i < 32; i++) read_check(5'(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
